// File: rtl/noobs_dmem.sv
`default_nettype none
// ============================================================================
// Module      : noobs_dmem
// Description : Data-memory responder for the NoobsCpu-8bit data port.
//               Synchronous byte RAM below MMIO_BASE plus a peripheral page
//               holding GPIO, a prescaled 16-bit timer and a sticky
//               access-error register. Read data is registered (1 cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module noobs_dmem #(
    parameter logic [11:0] MMIO_BASE      = 12'hF00,
    parameter int          TIMER_PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_en,
    input  logic        m_rd,
    input  logic        m_wr,
    input  logic [11:0] m_addr,
    input  logic [7:0]  m_wr_data,
    output logic [7:0]  m_rd_data,
    input  logic [7:0]  gpio_in,
    output logic [7:0]  gpio_out,
    output logic        timer_wrap,
    output logic        mem_err
);

    localparam int          c_AW     = $clog2(MMIO_BASE);
    localparam logic [7:0]  c_PS_MAX = 8'(TIMER_PRESCALE - 1);

    localparam logic [11:0] c_OFF_GPO  = 12'd0;
    localparam logic [11:0] c_OFF_GPI  = 12'd1;
    localparam logic [11:0] c_OFF_TLO  = 12'd2;
    localparam logic [11:0] c_OFF_THI  = 12'd3;
    localparam logic [11:0] c_OFF_TCTL = 12'd4;
    localparam logic [11:0] c_OFF_ERR  = 12'd5;

    // Access decode: a simultaneous read+write is a collision and does nothing
    // except flag the error.
    logic        w_rd;
    logic        w_wr;
    logic        w_coll;
    logic        w_is_mmio;
    logic [11:0] w_page_off;
    logic [c_AW-1:0] w_ram_idx;
    logic [7:0]  w_rd_val;

    assign w_rd       = m_en & m_rd & ~m_wr;
    assign w_wr       = m_en & m_wr & ~m_rd;
    assign w_coll     = m_en & m_rd & m_wr;
    assign w_is_mmio  = (m_addr >= MMIO_BASE);
    assign w_page_off = m_addr - MMIO_BASE;
    assign w_ram_idx  = m_addr[c_AW-1:0];

    logic [7:0]  r_ram [0:MMIO_BASE-1];
    logic [7:0]  r_rd_data;
    logic [7:0]  r_gpo;
    logic [7:0]  r_gpi_s1;
    logic [7:0]  r_gpi_s2;
    logic [7:0]  r_presc;
    logic [15:0] r_count;
    logic [7:0]  r_shadow;
    logic        r_ten;
    logic        r_wrap;
    logic        r_err;

    logic w_wr_gpo;
    logic w_wr_tctl;
    logic w_wr_err;
    logic w_rd_tlo;
    logic w_tclr;

    assign w_wr_gpo  = w_wr & w_is_mmio & (w_page_off == c_OFF_GPO);
    assign w_wr_tctl = w_wr & w_is_mmio & (w_page_off == c_OFF_TCTL);
    assign w_wr_err  = w_wr & w_is_mmio & (w_page_off == c_OFF_ERR);
    assign w_rd_tlo  = w_rd & w_is_mmio & (w_page_off == c_OFF_TLO);
    assign w_tclr    = w_wr_tctl & m_wr_data[1];

    // RAM storage: no reset, written only by non-colliding writes below the page.
    always_ff @(posedge clk) begin
        if (w_wr && !w_is_mmio) begin
            r_ram[w_ram_idx] <= m_wr_data;
        end
    end

    // Read-data source select for the current address.
    always_comb begin
        w_rd_val = 8'h00;
        if (!w_is_mmio) begin
            w_rd_val = r_ram[w_ram_idx];
        end else begin
            case (w_page_off)
                c_OFF_GPO:  w_rd_val = r_gpo;
                c_OFF_GPI:  w_rd_val = r_gpi_s2;
                c_OFF_TLO:  w_rd_val = r_count[7:0];
                c_OFF_THI:  w_rd_val = r_shadow;
                c_OFF_TCTL: w_rd_val = {7'b0, r_ten};
                c_OFF_ERR:  w_rd_val = {7'b0, r_err};
                default:    w_rd_val = 8'h00;
            endcase
        end
    end

    // Registered read data; holds unless a plain read is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data <= 8'h00;
        end else if (w_rd) begin
            r_rd_data <= w_rd_val;
        end
    end

    // Control registers: GPO, timer enable, HI shadow and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gpo    <= 8'h00;
            r_ten    <= 1'b0;
            r_shadow <= 8'h00;
            r_err    <= 1'b0;
        end else begin
            if (w_wr_gpo) begin
                r_gpo <= m_wr_data;
            end
            if (w_wr_tctl) begin
                r_ten <= m_wr_data[0];
            end
            // LO read latches the matching high byte so the pair is coherent.
            if (w_rd_tlo) begin
                r_shadow <= r_count[15:8];
            end
            if (w_coll) begin
                r_err <= 1'b1;
            end else if (w_wr_err && m_wr_data[0]) begin
                r_err <= 1'b0;
            end
        end
    end

    // Two-flop synchronizer for the asynchronous GPIO inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gpi_s1 <= 8'h00;
            r_gpi_s2 <= 8'h00;
        end else begin
            r_gpi_s1 <= gpio_in;
            r_gpi_s2 <= r_gpi_s1;
        end
    end

    // Prescaled timer; clear beats a same-cycle increment and kills the wrap pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= 8'h00;
            r_count <= 16'h0000;
            r_wrap  <= 1'b0;
        end else if (w_tclr) begin
            r_presc <= 8'h00;
            r_count <= 16'h0000;
            r_wrap  <= 1'b0;
        end else if (r_ten) begin
            if (r_presc == c_PS_MAX) begin
                r_presc <= 8'h00;
                r_count <= r_count + 16'd1;
                r_wrap  <= (r_count == 16'hFFFF);
            end else begin
                r_presc <= r_presc + 8'd1;
                r_wrap  <= 1'b0;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign m_rd_data  = r_rd_data;
    assign gpio_out   = r_gpo;
    assign timer_wrap = r_wrap;
    assign mem_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_noobs_dmem.sv
`default_nettype none
// ============================================================================
// Module      : tb_noobs_dmem
// Description : Directed bench for noobs_dmem: vector table for RAM/GPIO/ERR
//               plus hand sequences for timer, async reset and wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noobs_dmem;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    // main instance (prescale 4)
    logic        m_en = 1'b0, m_rd = 1'b0, m_wr = 1'b0;
    logic [11:0] m_addr = 12'h000;
    logic [7:0]  m_wr_data = 8'h00;
    logic [7:0]  m_rd_data;
    logic [7:0]  gpio_in = 8'h00;
    logic [7:0]  gpio_out;
    logic        timer_wrap;
    logic        mem_err;

    // second instance (prescale 1) for wrap and LO/HI coherence
    logic        b_en = 1'b0, b_rd = 1'b0, b_wr = 1'b0;
    logic [11:0] b_addr = 12'h000;
    logic [7:0]  b_wr_data = 8'h00;
    logic [7:0]  b_rd_data;
    logic [7:0]  b_gpio_out;
    logic        b_wrap;
    logic        b_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    noobs_dmem #(.MMIO_BASE(12'hF00), .TIMER_PRESCALE(4)) dut (
        .clk(clk), .reset(reset),
        .m_en(m_en), .m_rd(m_rd), .m_wr(m_wr),
        .m_addr(m_addr), .m_wr_data(m_wr_data), .m_rd_data(m_rd_data),
        .gpio_in(gpio_in), .gpio_out(gpio_out),
        .timer_wrap(timer_wrap), .mem_err(mem_err)
    );

    noobs_dmem #(.MMIO_BASE(12'hF00), .TIMER_PRESCALE(1)) dut2 (
        .clk(clk), .reset(reset),
        .m_en(b_en), .m_rd(b_rd), .m_wr(b_wr),
        .m_addr(b_addr), .m_wr_data(b_wr_data), .m_rd_data(b_rd_data),
        .gpio_in(8'h00), .gpio_out(b_gpio_out),
        .timer_wrap(b_wrap), .mem_err(b_err)
    );

    typedef struct {
        logic        en, rd, wr;
        logic [11:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rd;
        logic [7:0]  exp_gpo;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One access on the main instance, then strobes drop to idle.
    task automatic acc(input logic en, input logic rd, input logic wr,
                       input logic [11:0] addr, input logic [7:0] data);
        m_en = en; m_rd = rd; m_wr = wr; m_addr = addr; m_wr_data = data;
        @(posedge clk); #1;
        m_en = 1'b0; m_rd = 1'b0; m_wr = 1'b0;
    endtask

    task automatic acc2(input logic rd, input logic wr,
                        input logic [11:0] addr, input logic [7:0] data);
        b_en = 1'b1; b_rd = rd; b_wr = wr; b_addr = addr; b_wr_data = data;
        @(posedge clk); #1;
        b_en = 1'b0; b_rd = 1'b0; b_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        bit seen;

        //                en   rd   wr   addr     wdata  exp_rd exp_gpo err
        vecs[0]  = '{1'b1,1'b0,1'b1,12'h010,8'hA5,8'h00,8'h00,1'b0};
        vecs[1]  = '{1'b1,1'b1,1'b0,12'h010,8'h00,8'hA5,8'h00,1'b0};
        vecs[2]  = '{1'b1,1'b0,1'b1,12'hEFF,8'h3C,8'hA5,8'h00,1'b0};
        vecs[3]  = '{1'b1,1'b1,1'b0,12'hEFF,8'h00,8'h3C,8'h00,1'b0};
        vecs[4]  = '{1'b1,1'b0,1'b1,12'hF00,8'h5A,8'h3C,8'h5A,1'b0};
        vecs[5]  = '{1'b1,1'b1,1'b0,12'hF00,8'h00,8'h5A,8'h5A,1'b0};
        vecs[6]  = '{1'b1,1'b1,1'b0,12'hF80,8'h00,8'h00,8'h5A,1'b0};
        vecs[7]  = '{1'b1,1'b1,1'b0,12'h010,8'h00,8'hA5,8'h5A,1'b0};
        vecs[8]  = '{1'b1,1'b1,1'b1,12'h010,8'hFF,8'hA5,8'h5A,1'b1};
        vecs[9]  = '{1'b1,1'b1,1'b0,12'h010,8'h00,8'hA5,8'h5A,1'b1};
        vecs[10] = '{1'b1,1'b1,1'b0,12'hF05,8'h00,8'h01,8'h5A,1'b1};
        vecs[11] = '{1'b1,1'b0,1'b1,12'hF05,8'h01,8'h01,8'h5A,1'b0};
        vecs[12] = '{1'b1,1'b1,1'b0,12'hF05,8'h00,8'h00,8'h5A,1'b0};
        vecs[13] = '{1'b1,1'b0,1'b1,12'hF06,8'h77,8'h00,8'h5A,1'b0};
        vecs[14] = '{1'b1,1'b1,1'b0,12'hF06,8'h00,8'h00,8'h5A,1'b0};
        vecs[15] = '{1'b0,1'b1,1'b0,12'hF04,8'h00,8'h00,8'h5A,1'b0};

        // reset state
        #12;
        chk("reset_rd_data", {8'h0, m_rd_data}, 16'h0000);
        chk("reset_gpio_out", {8'h0, gpio_out}, 16'h0000);
        chk("reset_err_wrap", {14'h0, mem_err, timer_wrap}, 16'h0000);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        // RAM / GPIO / ERR vector table
        for (int i = 0; i < 16; i++) begin
            acc(vecs[i].en, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("vec%0d_rd", i), {8'h0, m_rd_data}, {8'h0, vecs[i].exp_rd});
            chk($sformatf("vec%0d_gpo", i), {8'h0, gpio_out}, {8'h0, vecs[i].exp_gpo});
            chk($sformatf("vec%0d_err", i), {15'h0, mem_err}, {15'h0, vecs[i].exp_err});
        end
        acc(1, 1, 0, 12'hF04, 8'h00);
        chk("tctl_reset", {8'h0, m_rd_data}, 16'h0000);

        // GPI through the synchronizer
        gpio_in = 8'hC3;
        idle(2);
        acc(1, 1, 0, 12'hF01, 8'h00);
        chk("gpi_read", {8'h0, m_rd_data}, 16'h00C3);

        // idle hold with random strobes while disabled
        acc(1, 1, 0, 12'h010, 8'h00);
        chk("hold_pre", {8'h0, m_rd_data}, 16'h00A5);
        for (int i = 0; i < 10; i++) begin
            m_en = 1'b0; m_rd = 1'($urandom); m_wr = 1'($urandom);
            m_addr = 12'($urandom); m_wr_data = 8'($urandom);
            @(posedge clk); #1;
            chk($sformatf("hold%0d", i), {7'h0, mem_err, m_rd_data}, 16'h00A5);
        end
        m_rd = 1'b0; m_wr = 1'b0;
        chk("hold_gpo", {8'h0, gpio_out}, 16'h005A);
        acc(1, 1, 0, 12'h010, 8'h00);
        chk("hold_ram", {8'h0, m_rd_data}, 16'h00A5);
        acc(1, 1, 0, 12'hF04, 8'h00);
        chk("hold_tctl", {8'h0, m_rd_data}, 16'h0000);

        // timer, prescale 4: 40 edges after enable -> count 10
        acc(1, 0, 1, 12'hF04, 8'h01);
        idle(40);
        acc(1, 1, 0, 12'hF02, 8'h00);
        chk("tmr_lo_40", {8'h0, m_rd_data}, 16'h000A);
        acc(1, 1, 0, 12'hF03, 8'h00);
        chk("tmr_hi_40", {8'h0, m_rd_data}, 16'h0000);

        // clear: count restarts from 0, enable survives, clear reads 0
        acc(1, 0, 1, 12'hF04, 8'h03);
        acc(1, 1, 0, 12'hF02, 8'h00);
        chk("tmr_clr_lo", {8'h0, m_rd_data}, 16'h0000);
        acc(1, 1, 0, 12'hF03, 8'h00);
        chk("tmr_clr_hi", {8'h0, m_rd_data}, 16'h0000);
        acc(1, 1, 0, 12'hF04, 8'h00);
        chk("tctl_after_clr", {8'h0, m_rd_data}, 16'h0001);

        // asynchronous reset mid-cycle with non-zero state
        acc(1, 1, 1, 12'h010, 8'hFF);
        chk("coll_err", {15'h0, mem_err}, 16'h0001);
        #3 reset = 1'b1;
        #1;
        chk("async_rd", {8'h0, m_rd_data}, 16'h0000);
        chk("async_gpo", {8'h0, gpio_out}, 16'h0000);
        chk("async_err_wrap", {14'h0, mem_err, timer_wrap}, 16'h0000);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        acc(1, 1, 0, 12'hF04, 8'h00);
        chk("post_reset_tctl", {8'h0, m_rd_data}, 16'h0000);

        // prescale-1 instance: LO/HI coherence across 00FF -> 0100
        acc2(0, 1, 12'hF04, 8'h01);
        c0 = cyc;
        idle(255);
        acc2(1, 0, 12'hF02, 8'h00);
        chk("coh_lo", {8'h0, b_rd_data}, 16'h00FF);
        acc2(1, 0, 12'hF03, 8'h00);
        chk("coh_hi", {8'h0, b_rd_data}, 16'h0000);

        // wrap pulse: count reaches 0 again 65536 edges after enable
        seen = 1'b0;
        for (int i = 0; i < 70000 && !seen; i++) begin
            @(posedge clk); #1;
            if (b_wrap) seen = 1'b1;
        end
        chk("wrap_seen", {15'h0, seen}, 16'h0001);
        chk("wrap_cycle", 16'(cyc - c0), 16'h0000);
        @(posedge clk); #1;
        chk("wrap_one_cycle", {15'h0, b_wrap}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
